// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the reset sequencer slice.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    DONE      = 3'd3,
    SHUTDOWN  = 3'd4
  } state_t;

  // Width of a counter that must hold values up to the largest of the three limits.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/lock_filter.sv
// PLL lock synchroniser plus consecutive-high qualification counter.
module lock_filter
  import reset_seq_pkg::*;
#(
  parameter int unsigned LOCK_FILTER = 8
) (
  input  logic clk,
  input  logic sync_reset,
  input  logic pll_locked,
  input  logic enable,
  output logic pll_lk,
  output logic lock_ok
);

  localparam int unsigned FW = cnt_width(LOCK_FILTER, 1, 1);
  localparam logic [FW-1:0] LAST = FW'(LOCK_FILTER - 1);

  logic          meta;
  logic [FW-1:0] cnt;

  // lock_ok flags the cycle whose edge completes the LOCK_FILTER-th consecutive high.
  assign lock_ok = enable && pll_lk && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      meta   <= 1'b0;
      pll_lk <= 1'b0;
      cnt    <= '0;
    end else begin
      meta   <= pll_locked;
      pll_lk <= meta;
      if (!enable || !pll_lk) begin
        cnt <= '0;
      end else if (!lock_ok) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered multi-domain reset release with lock qualification, lock-loss
// re-sequencing and software-requested reverse-order shutdown.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 3,
  parameter int unsigned MIN_ASSERT  = 16,
  parameter int unsigned LOCK_FILTER = 8,
  parameter int unsigned STAGE_DELAY = 32,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  pll_locked,
  input  logic                  soft_reset_req,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  seq_done,
  output logic [2:0]            seq_state,
  output logic [CNT_WIDTH-1:0]  restart_count
);

  localparam int unsigned TW = cnt_width(MIN_ASSERT, LOCK_FILTER, STAGE_DELAY);
  localparam int unsigned IW = $clog2(NUM_STAGES + 1);
  localparam logic [TW-1:0] IDLE_LAST  = TW'(MIN_ASSERT - 1);
  localparam logic [TW-1:0] DELAY_LAST = TW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] LAST_STAGE = IW'(NUM_STAGES - 1);

  state_t                state, state_n;
  logic [TW-1:0]         timer, timer_n;
  logic [IW-1:0]         idx, idx_n;
  logic [NUM_STAGES-1:0] stage_n;
  logic                  done_n;
  logic                  restart;
  logic                  pll_lk;
  logic                  lock_ok;
  logic                  active;

  lock_filter #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock_filter (
    .clk       (clk),
    .sync_reset(sync_reset),
    .pll_locked(pll_locked),
    .enable    (state == WAIT_LOCK),
    .pll_lk    (pll_lk),
    .lock_ok   (lock_ok)
  );

  assign seq_state = state;
  assign active    = (state == RELEASE) || (state == DONE) || (state == SHUTDOWN);

  always_comb begin
    state_n = state;
    timer_n = timer;
    idx_n   = idx;
    stage_n = stage_reset;
    done_n  = seq_done;
    restart = 1'b0;

    // Lock loss overrides everything, including a coincident soft request.
    if (active && !pll_lk) begin
      state_n = IDLE;
      timer_n = '0;
      stage_n = '1;
      done_n  = 1'b0;
      restart = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          stage_n = '1;
          done_n  = 1'b0;
          if (timer == IDLE_LAST) begin
            state_n = WAIT_LOCK;
            timer_n = '0;
          end else begin
            timer_n = timer + 1'b1;
          end
        end

        WAIT_LOCK: begin
          stage_n = '1;
          if (lock_ok) begin
            state_n = RELEASE;
            timer_n = '0;
            idx_n   = '0;
          end
        end

        RELEASE: begin
          if (soft_reset_req) begin
            timer_n = '0;
            if (idx == '0) begin
              state_n = IDLE;
              stage_n = '1;
              restart = 1'b1;
            end else begin
              state_n = SHUTDOWN;
            end
          end else if (timer == DELAY_LAST) begin
            timer_n = '0;
            idx_n   = idx + 1'b1;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
              if (IW'(k) == idx) stage_n[k] = 1'b0;
            end
            if (idx == LAST_STAGE) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end else begin
            timer_n = timer + 1'b1;
          end
        end

        DONE: begin
          stage_n = '0;
          if (soft_reset_req) begin
            state_n = SHUTDOWN;
            timer_n = '0;
            done_n  = 1'b0;
          end
        end

        SHUTDOWN: begin
          // idx counts released stages, so stage idx-1 is the next to reassert.
          if (timer == DELAY_LAST) begin
            timer_n = '0;
            idx_n   = idx - 1'b1;
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
              if (IW'(k + 1) == idx) stage_n[k] = 1'b1;
            end
            if (idx <= IW'(1)) begin
              state_n = IDLE;
              stage_n = '1;
              restart = 1'b1;
            end
          end else begin
            timer_n = timer + 1'b1;
          end
        end

        default: begin
          state_n = IDLE;
          timer_n = '0;
          stage_n = '1;
          done_n  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      state         <= IDLE;
      timer         <= '0;
      idx           <= '0;
      stage_reset   <= '1;
      seq_done      <= 1'b0;
      restart_count <= '0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      idx         <= idx_n;
      stage_reset <= stage_n;
      seq_done    <= done_n;
      if (restart && (restart_count != '1)) restart_count <= restart_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default-parameter instance A plus a
// small CNT_WIDTH=2 instance B for saturation and mid-shutdown reset.
module tb_reset_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_REL  = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_SHUT = 3'd4;

  logic       clk = 1'b0;
  logic       sync_reset, pll_locked, soft_reset_req;
  logic [2:0] stage_reset;
  logic       seq_done;
  logic [2:0] seq_state;
  logic [7:0] restart_count;

  logic       sync_reset_b, pll_locked_b, soft_reset_req_b;
  logic [1:0] stage_reset_b;
  logic       seq_done_b;
  logic [2:0] seq_state_b;
  logic [1:0] restart_count_b;

  int checks   = 0;
  int failures = 0;
  int now      = 0;

  always #5 clk = ~clk;

  reset_sequencer u_dut_a (
    .clk           (clk),
    .sync_reset    (sync_reset),
    .pll_locked    (pll_locked),
    .soft_reset_req(soft_reset_req),
    .stage_reset   (stage_reset),
    .seq_done      (seq_done),
    .seq_state     (seq_state),
    .restart_count (restart_count)
  );

  reset_sequencer #(
    .NUM_STAGES (2),
    .MIN_ASSERT (2),
    .LOCK_FILTER(2),
    .STAGE_DELAY(3),
    .CNT_WIDTH  (2)
  ) u_dut_b (
    .clk           (clk),
    .sync_reset    (sync_reset_b),
    .pll_locked    (pll_locked_b),
    .soft_reset_req(soft_reset_req_b),
    .stage_reset   (stage_reset_b),
    .seq_done      (seq_done_b),
    .seq_state     (seq_state_b),
    .restart_count (restart_count_b)
  );

  typedef struct {
    int         cyc;
    logic [2:0] rst;
    logic       done;
    logic [2:0] st;
    logic [7:0] rc;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, now, got, exp);
    end
  endtask

  // One clock; outputs sampled on the falling edge, ordering invariant checked every cycle.
  task automatic step();
    logic [2:0] inv_a;
    logic [1:0] inv_b;
    @(negedge clk);
    now++;
    inv_a = ~stage_reset;
    inv_b = ~stage_reset_b;
    chk("order_a", {31'd0, ((inv_a & (inv_a + 3'd1)) == 3'd0)}, 32'd1);
    chk("order_b", {31'd0, ((inv_b & (inv_b + 2'd1)) == 2'd0)}, 32'd1);
  endtask

  task automatic goto(input int n);
    while (now < n) step();
  endtask

  task automatic expect_a(input string tag, input logic [2:0] rst, input logic done,
                          input logic [2:0] st, input logic [7:0] rc);
    chk({tag, "_rst"},   {29'd0, stage_reset},   {29'd0, rst});
    chk({tag, "_done"},  {31'd0, seq_done},      {31'd0, done});
    chk({tag, "_state"}, {29'd0, seq_state},     {29'd0, st});
    chk({tag, "_rc"},    {24'd0, restart_count}, {24'd0, rc});
  endtask

  task automatic at(input int n, input string tag, input logic [2:0] rst, input logic done,
                    input logic [2:0] st, input logic [7:0] rc);
    goto(n);
    expect_a(tag, rst, done, st, rc);
  endtask

  task automatic wait_done_b(output logic ok);
    int n;
    n = 0;
    while (!seq_done_b && n < 200) begin
      step();
      n++;
    end
    ok = seq_done_b;
  endtask

  initial begin
    logic released;
    logic ok;

    sync_reset = 1'b1;  pll_locked = 1'b1;  soft_reset_req = 1'b0;
    sync_reset_b = 1'b1; pll_locked_b = 1'b1; soft_reset_req_b = 1'b0;
    repeat (3) step();
    expect_a("reset", 3'b111, 1'b0, S_IDLE, 8'd0);
    chk("b_reset_rst", {30'd0, stage_reset_b}, 32'h3);
    chk("b_reset_state", {29'd0, seq_state_b}, {29'd0, S_IDLE});

    // Scenario 1: nominal release, cycles counted in edges after sync_reset falls.
    tbl.push_back('{15,  3'b111, 1'b0, S_IDLE, 8'd0});
    tbl.push_back('{16,  3'b111, 1'b0, S_WAIT, 8'd0});
    tbl.push_back('{23,  3'b111, 1'b0, S_WAIT, 8'd0});
    tbl.push_back('{24,  3'b111, 1'b0, S_REL,  8'd0});
    tbl.push_back('{55,  3'b111, 1'b0, S_REL,  8'd0});
    tbl.push_back('{56,  3'b110, 1'b0, S_REL,  8'd0});
    tbl.push_back('{87,  3'b110, 1'b0, S_REL,  8'd0});
    tbl.push_back('{88,  3'b100, 1'b0, S_REL,  8'd0});
    tbl.push_back('{119, 3'b100, 1'b0, S_REL,  8'd0});
    tbl.push_back('{120, 3'b000, 1'b1, S_DONE, 8'd0});
    tbl.push_back('{130, 3'b000, 1'b1, S_DONE, 8'd0});
    sync_reset = 1'b0;
    now = 0;
    foreach (tbl[i]) begin
      goto(tbl[i].cyc);
      expect_a($sformatf("s1_c%0d", tbl[i].cyc), tbl[i].rst, tbl[i].done, tbl[i].st, tbl[i].rc);
    end

    // Scenario 2: lock toggling every 5 cycles never qualifies.
    sync_reset = 1'b1; pll_locked = 1'b0;
    step(); step();
    sync_reset = 1'b0;
    now = 0;
    released = 1'b0;
    for (int c = 0; c < 200; c++) begin
      pll_locked = ((c / 5) % 2 == 0);
      step();
      if (stage_reset !== 3'b111) released = 1'b1;
    end
    chk("s2_no_release", {31'd0, released}, 32'd0);
    expect_a("s2_c200", 3'b111, 1'b0, S_WAIT, 8'd0);
    pll_locked = 1'b1;
    at(209, "s2_c209", 3'b111, 1'b0, S_WAIT, 8'd0);
    at(210, "s2_c210", 3'b111, 1'b0, S_REL,  8'd0);
    at(241, "s2_c241", 3'b111, 1'b0, S_REL,  8'd0);
    at(242, "s2_c242", 3'b110, 1'b0, S_REL,  8'd0);
    at(306, "s2_c306", 3'b000, 1'b1, S_DONE, 8'd0);

    // Scenario 3: one-cycle lock drop in DONE.
    goto(310);
    pll_locked = 1'b0;
    step();
    pll_locked = 1'b1;
    at(312, "s3_c312", 3'b000, 1'b1, S_DONE, 8'd0);
    at(313, "s3_c313", 3'b111, 1'b0, S_IDLE, 8'd1);
    at(368, "s3_c368", 3'b111, 1'b0, S_REL,  8'd1);
    at(369, "s3_c369", 3'b110, 1'b0, S_REL,  8'd1);
    at(432, "s3_c432", 3'b100, 1'b0, S_REL,  8'd1);
    at(433, "s3_c433", 3'b000, 1'b1, S_DONE, 8'd1);

    // Scenario 4: soft shutdown from DONE; extra requests in SHUTDOWN and IDLE are ignored.
    goto(440);
    soft_reset_req = 1'b1; step(); soft_reset_req = 1'b0;
    at(441, "s4_c441", 3'b000, 1'b0, S_SHUT, 8'd1);
    at(472, "s4_c472", 3'b000, 1'b0, S_SHUT, 8'd1);
    at(473, "s4_c473", 3'b100, 1'b0, S_SHUT, 8'd1);
    goto(480);
    soft_reset_req = 1'b1; step(); soft_reset_req = 1'b0;
    at(504, "s4_c504", 3'b100, 1'b0, S_SHUT, 8'd1);
    at(505, "s4_c505", 3'b110, 1'b0, S_SHUT, 8'd1);
    at(536, "s4_c536", 3'b110, 1'b0, S_SHUT, 8'd1);
    at(537, "s4_c537", 3'b111, 1'b0, S_IDLE, 8'd2);
    goto(540);
    soft_reset_req = 1'b1; step(); soft_reset_req = 1'b0;
    at(552, "s4_c552", 3'b111, 1'b0, S_IDLE, 8'd2);
    at(553, "s4_c553", 3'b111, 1'b0, S_WAIT, 8'd2);
    at(561, "s4_c561", 3'b111, 1'b0, S_REL,  8'd2);
    at(592, "s4_c592", 3'b111, 1'b0, S_REL,  8'd2);
    at(593, "s4_c593", 3'b110, 1'b0, S_REL,  8'd2);
    at(657, "s4_c657", 3'b000, 1'b1, S_DONE, 8'd2);

    // Scenario 5: lock loss and soft request reach the FSM on the same edge
    // (pll_locked dropped two cycles early to cover the synchroniser latency).
    goto(660);
    sync_reset = 1'b1;
    step();
    expect_a("s5_rst", 3'b111, 1'b0, S_IDLE, 8'd0);
    step();
    sync_reset = 1'b0;
    now = 0;
    at(56, "s5_c56", 3'b110, 1'b0, S_REL, 8'd0);
    goto(60);
    pll_locked = 1'b0;
    at(62, "s5_c62", 3'b110, 1'b0, S_REL, 8'd0);
    soft_reset_req = 1'b1; step(); soft_reset_req = 1'b0;
    expect_a("s5_c63", 3'b111, 1'b0, S_IDLE, 8'd1);
    goto(70);
    pll_locked = 1'b1;
    at(100, "s5_c100", 3'b111, 1'b0, S_REL, 8'd1);

    // Scenario 6: small instance B, saturation then sync_reset mid-SHUTDOWN.
    sync_reset_b = 1'b0;
    now = 0;
    goto(6);
    chk("b_c6_rst", {30'd0, stage_reset_b}, 32'h3);
    goto(7);
    chk("b_c7_rst", {30'd0, stage_reset_b}, 32'h2);
    goto(9);
    chk("b_c9_rst", {30'd0, stage_reset_b}, 32'h2);
    goto(10);
    chk("b_c10_rst", {30'd0, stage_reset_b}, 32'h0);
    chk("b_c10_done", {31'd0, seq_done_b}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      wait_done_b(ok);
      chk($sformatf("b_done_%0d", i), {31'd0, ok}, 32'd1);
      pll_locked_b = 1'b0;
      repeat (4) step();
      pll_locked_b = 1'b1;
      chk($sformatf("b_rc_%0d", i), {30'd0, restart_count_b}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      chk($sformatf("b_rst_%0d", i), {30'd0, stage_reset_b}, 32'h3);
    end
    wait_done_b(ok);
    chk("b_done_final", {31'd0, ok}, 32'd1);
    soft_reset_req_b = 1'b1; step(); soft_reset_req_b = 1'b0;
    step();
    chk("b_shut_state", {29'd0, seq_state_b}, {29'd0, S_SHUT});
    chk("b_shut_rc", {30'd0, restart_count_b}, 32'd3);
    sync_reset_b = 1'b1;
    step();
    chk("b_sr_rc", {30'd0, restart_count_b}, 32'd0);
    chk("b_sr_rst", {30'd0, stage_reset_b}, 32'h3);
    chk("b_sr_state", {29'd0, seq_state_b}, {29'd0, S_IDLE});
    chk("b_sr_done", {31'd0, seq_done_b}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
